// File: rtl/game_pkg.sv
// Shared game constants and the shot controller state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

    localparam logic [2:0] MAG_SIZE  = 3'd3;
    localparam logic [6:0] SCORE_MAX = 7'd99;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READY  = 2'd1,
        HOLD   = 2'd2,
        RELOAD = 2'd3
    } shot_state_t;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector: registers the previous level, pulses on low->high.
// Latency: pulse is combinational in the cycle the input first reads high.
// Backpressure: none; level input, single-cycle pulse output.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic btn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn;
        end
    end

    assign pulse = btn & ~btn_q;

endmodule

// File: rtl/shot_ctl.sv
// Shot controller: magazine, reload timer, duck hit test and score.
// Latency: 1 cycle from button edge to registered outputs; no backpressure.
// Optional SHOT_CTL_AUTO_RELOAD_EN: an empty magazine reloads on left release.
module shot_ctl
    import game_pkg::*;
#(
    parameter int unsigned RELOAD_TICKS = 32500000,
    parameter int unsigned HIT_W        = 64,
    parameter int unsigned HIT_H        = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_enable,
    input  logic        left,
    input  logic        right,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [11:0] duck_x,
    input  logic [11:0] duck_y,
    input  logic        duck_active,
    input  logic        new_duck,
    output logic [2:0]  bullets_in_magazine,
    output logic [6:0]  bin_number,
    output logic        target_killed,
    output logic        shot_fired
);

    localparam int unsigned CNT_W = (RELOAD_TICKS > 1) ? $clog2(RELOAD_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (RELOAD_TICKS > 0) ? CNT_W'(RELOAD_TICKS - 1) : '0;

    shot_state_t      state;
    logic [CNT_W-1:0] reload_cnt;
    logic             left_edge;
    logic             right_edge;
    logic             hit;
    logic             reload_done;
    logic [12:0]      x_lo, x_hi, x_cur, y_lo, y_hi, y_cur;

    btn_edge u_left_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (left),
        .pulse (left_edge)
    );

    btn_edge u_right_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (right),
        .pulse (right_edge)
    );

    // 13-bit bounds so a duck near the right/bottom edge cannot wrap.
    assign x_lo  = {1'b0, duck_x};
    assign y_lo  = {1'b0, duck_y};
    assign x_hi  = x_lo + 13'(HIT_W);
    assign y_hi  = y_lo + 13'(HIT_H);
    assign x_cur = {1'b0, xpos};
    assign y_cur = {1'b0, ypos};

    assign hit = duck_active
               && (x_lo <= x_cur) && (x_cur < x_hi)
               && (y_lo <= y_cur) && (y_cur < y_hi);

    assign reload_done = (reload_cnt >= CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            reload_cnt          <= '0;
            bullets_in_magazine <= MAG_SIZE;
            bin_number          <= 7'd0;
            target_killed       <= 1'b0;
            shot_fired          <= 1'b0;
        end else begin
            shot_fired <= 1'b0;
            // A hit later in this block overrides the clear.
            if (new_duck) begin
                target_killed <= 1'b0;
            end

            if (!game_enable) begin
                state               <= IDLE;
                reload_cnt          <= '0;
                bullets_in_magazine <= MAG_SIZE;
            end else begin
                case (state)
                    IDLE: begin
                        state               <= READY;
                        bin_number          <= 7'd0;
                        bullets_in_magazine <= MAG_SIZE;
                        target_killed       <= 1'b0;
                    end

                    READY: begin
                        if (left_edge) begin
                            if (bullets_in_magazine != 3'd0) begin
                                bullets_in_magazine <= bullets_in_magazine - 3'd1;
                                shot_fired          <= 1'b1;
                                state               <= HOLD;
                                if (hit) begin
                                    target_killed <= 1'b1;
                                    if (!target_killed && (bin_number < SCORE_MAX)) begin
                                        bin_number <= bin_number + 7'd1;
                                    end
                                end
                            end
                        end else if (right_edge && (bullets_in_magazine < MAG_SIZE)) begin
                            state      <= RELOAD;
                            reload_cnt <= '0;
                        end
                    end

                    HOLD: begin
                        if (!left) begin
`ifdef SHOT_CTL_AUTO_RELOAD_EN
                            state      <= (bullets_in_magazine == 3'd0) ? RELOAD : READY;
                            reload_cnt <= '0;
`else
                            state <= READY;
`endif
                        end
                    end

                    RELOAD: begin
                        if (reload_done) begin
                            bullets_in_magazine <= MAG_SIZE;
                            reload_cnt          <= '0;
                            state               <= READY;
                        end else begin
                            reload_cnt <= reload_cnt + 1'b1;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shot_ctl.sv
// Directed bench for shot_ctl with a 16-cycle reload.
module tb_shot_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        game_enable;
    logic        left;
    logic        right;
    logic [11:0] xpos, ypos, duck_x, duck_y;
    logic        duck_active;
    logic        new_duck;
    logic [2:0]  bullets_in_magazine;
    logic [6:0]  bin_number;
    logic        target_killed;
    logic        shot_fired;

    int n_cmp = 0;
    int n_err = 0;
    int exp_score;
    int exp_bul;
    int pulses;

    always #5 clk = ~clk;

    shot_ctl #(
        .RELOAD_TICKS (16),
        .HIT_W        (64),
        .HIT_H        (64)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .game_enable         (game_enable),
        .left                (left),
        .right               (right),
        .xpos                (xpos),
        .ypos                (ypos),
        .duck_x              (duck_x),
        .duck_y              (duck_y),
        .duck_active         (duck_active),
        .new_duck            (new_duck),
        .bullets_in_magazine (bullets_in_magazine),
        .bin_number          (bin_number),
        .target_killed       (target_killed),
        .shot_fired          (shot_fired)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_left();
        left = 1'b0;
        tick();
        tick();
    endtask

    task automatic reload();
        right = 1'b1;
        tick();
        right = 1'b0;
        repeat (16) tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; game_enable = 1'b0; left = 1'b0; right = 1'b0;
        xpos = '0; ypos = '0; duck_x = 12'd200; duck_y = 12'd300;
        duck_active = 1'b1; new_duck = 1'b0;
        tick();
        tick();
        check("rst_bullets", bullets_in_magazine, 3);
        check("rst_score", bin_number, 0);
        check("rst_killed", target_killed, 0);
        check("rst_shot", shot_fired, 0);

        rst = 1'b0;
        tick();
        game_enable = 1'b1;
        tick();
        check("start_bullets", bullets_in_magazine, 3);

        // Hit inside the box.
        xpos = 12'd210; ypos = 12'd310;
        left = 1'b1;
        tick();
        check("hit_shot", shot_fired, 1);
        check("hit_bullets", bullets_in_magazine, 2);
        check("hit_killed", target_killed, 1);
        check("hit_score", bin_number, 1);
        tick();
        check("hit_shot_1cyc", shot_fired, 0);
        release_left();

        // Re-enter the game: score cleared, magazine full.
        game_enable = 1'b0;
        tick();
        tick();
        check("ge0_score_hold", bin_number, 1);
        game_enable = 1'b1;
        tick();
        check("ge1_score", bin_number, 0);
        check("ge1_killed", target_killed, 0);

        // x = duck_x + HIT_W is outside.
        xpos = 12'd264; ypos = 12'd310;
        left = 1'b1;
        tick();
        check("xedge_shot", shot_fired, 1);
        check("xedge_bullets", bullets_in_magazine, 2);
        check("xedge_killed", target_killed, 0);
        check("xedge_score", bin_number, 0);
        release_left();

        // y = duck_y + HIT_H is outside.
        xpos = 12'd210; ypos = 12'd364;
        left = 1'b1;
        tick();
        check("yedge_killed", target_killed, 0);
        check("yedge_bullets", bullets_in_magazine, 1);
        release_left();

        // x just left of the box.
        xpos = 12'd199; ypos = 12'd310;
        left = 1'b1;
        tick();
        check("xlow_killed", target_killed, 0);
        check("empty_bullets", bullets_in_magazine, 0);
        release_left();

        left = 1'b1;
        tick();
        check("dry_shot", shot_fired, 0);
        check("dry_bullets", bullets_in_magazine, 0);
        release_left();

        // Reload timing, with left clicks ignored throughout.
        right = 1'b1;
        tick();
        right = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 15; i++) begin
            left = (i >= 3 && i <= 6);
            tick();
            if (shot_fired) pulses++;
        end
        check("reload_left_ignored", pulses, 0);
        check("reload_15", bullets_in_magazine, 0);
        tick();
        check("reload_16", bullets_in_magazine, 3);
        tick();

        // Hold at the far inside corner for 100 cycles: one shot.
        xpos = 12'd263; ypos = 12'd363;
        left = 1'b1;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (shot_fired) pulses++;
        end
        check("hold_pulses", pulses, 1);
        check("hold_bullets", bullets_in_magazine, 2);
        check("corner_killed", target_killed, 1);
        check("corner_score", bin_number, 1);
        release_left();

        // Hit with new_duck in the same cycle: stays killed.
        left = 1'b1;
        new_duck = 1'b1;
        tick();
        new_duck = 1'b0;
        check("newduck_hit_killed", target_killed, 1);
        check("newduck_hit_score", bin_number, 1);
        check("newduck_hit_bullets", bullets_in_magazine, 1);
        release_left();

        new_duck = 1'b1;
        tick();
        new_duck = 1'b0;
        check("newduck_clear", target_killed, 0);

        // Left and right edges together: shot wins, inactive duck is not hit.
        duck_active = 1'b0;
        left = 1'b1;
        right = 1'b1;
        tick();
        check("both_shot", shot_fired, 1);
        check("inactive_killed", target_killed, 0);
        check("both_bullets", bullets_in_magazine, 0);
        release_left();
        right = 1'b0;
        repeat (20) tick();
        check("no_auto_reload", bullets_in_magazine, 0);
        reload();
        check("reload_again", bullets_in_magazine, 3);

        // Drive the score to saturation.
        duck_active = 1'b1;
        xpos = 12'd230; ypos = 12'd330;
        exp_score = 1;
        exp_bul = 3;
        for (int i = 0; i < 100; i++) begin
            new_duck = 1'b1;
            tick();
            new_duck = 1'b0;
            left = 1'b1;
            tick();
            release_left();
            exp_score = (exp_score < 99) ? exp_score + 1 : 99;
            exp_bul--;
            if (exp_bul == 0) begin
                reload();
                exp_bul = 3;
            end
        end
        check("sat_score", bin_number, exp_score);
        check("sat_score_99", bin_number, 99);
        check("sat_bullets", bullets_in_magazine, exp_bul);

        game_enable = 1'b0;
        tick();
        tick();
        check("end_score", bin_number, 99);
        check("end_bullets", bullets_in_magazine, 3);
        game_enable = 1'b1;
        tick();
        check("restart_score", bin_number, 0);
        check("restart_bullets", bullets_in_magazine, 3);
        tick();

        // Reset in the middle of a reload.
        left = 1'b1;
        tick();
        release_left();
        right = 1'b1;
        tick();
        right = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midrst_bullets", bullets_in_magazine, 3);
        check("midrst_shot", shot_fired, 0);
        rst = 1'b0;
        tick();
        tick();
        check("postrst_bullets", bullets_in_magazine, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shot_ctl.md
SHOT_CTL -- requirements
Module: shot_ctl

Interface
REQ-001 SHALL have parameter RELOAD_TICKS, default 32500000, clk cycles spent in reload (0.5 s at 65 MHz).
REQ-002 SHALL have parameter HIT_W, default 64, duck hitbox width in pixels.
REQ-003 SHALL have parameter HIT_H, default 64, duck hitbox height in pixels.
REQ-004 clk  in  1  65 MHz pixel clock; the only clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 game_enable  in  1  high while in the game stage.
REQ-007 left  in  1  mouse left-button level, already synchronous to clk.
REQ-008 right  in  1  mouse right-button level (reload request).
REQ-009 xpos, ypos  in  12 each  cursor position.
REQ-010 duck_x, duck_y  in  12 each  duck top-left corner.
REQ-011 duck_active  in  1  duck is on screen and shootable.
REQ-012 new_duck  in  1  one-cycle pulse: a new duck has spawned.
REQ-013 bullets_in_magazine  out  3  rounds left, 0..MAG_SIZE.
REQ-014 bin_number  out  7  score, binary, feeds the score drawer.
REQ-015 target_killed  out  1  level, held from hit until new_duck.
REQ-016 shot_fired  out  1  one-cycle pulse per accepted shot.

Function
REQ-017 SHALL implement FSM IDLE, READY, HOLD, RELOAD.
REQ-018 IDLE: game_enable=1 -> READY; on that transition bin_number:=0, bullets:=MAG_SIZE, target_killed:=0.
REQ-019 Any state, game_enable=0 -> IDLE next cycle; bin_number holds (end screen shows it), bullets:=MAG_SIZE.
REQ-020 Shot edge = left high this cycle and low the previous cycle; edges only detected in READY.
REQ-021 READY, edge, bullets>0: next cycle bullets-1, shot_fired=1, state HOLD.
REQ-022 Hit = duck_active and duck_x<=xpos<duck_x+HIT_W and duck_y<=ypos<duck_y+HIT_H, evaluated in the edge cycle with 13-bit sums (no wrap).
REQ-023 Hit with target_killed=0: next cycle target_killed=1, bin_number+1, saturating at SCORE_MAX=99.
REQ-024 Hit with target_killed=1: shot consumed, score unchanged.
REQ-025 READY, edge, bullets=0: no shot_fired, no decrement, state unchanged.
REQ-026 HOLD: stay until left=0, then READY (one shot per press).
REQ-027 READY, right rising edge, bullets<MAG_SIZE, no left edge that cycle: -> RELOAD; left and right edges together: shot wins.
REQ-028 RELOAD: count RELOAD_TICKS cycles, then bullets:=MAG_SIZE, -> READY; left ignored throughout.
REQ-029 new_duck clears target_killed next cycle; a hit in the same cycle wins (target_killed=1).
REQ-030 All outputs registered; latency edge-to-output exactly 1 cycle.

Reset
REQ-031 rst: state IDLE, bullets_in_magazine=MAG_SIZE, bin_number=0, target_killed=0, shot_fired=0, reload counter 0, edge registers 0.
REQ-032 rst mid-RELOAD or mid-HOLD SHALL abort to those values with no shot_fired.

Configuration
REQ-033 Macro SHOT_CTL_AUTO_RELOAD_EN defined: a shot leaving bullets=0 SHALL go HOLD then, on left release, RELOAD automatically.
REQ-034 Macro undefined: bullets=0 stays in READY until a right edge starts RELOAD.

Structure
REQ-035 game_pkg SHALL hold MAG_SIZE=3, SCORE_MAX=99 and the shot_ctl state enum typedef.
REQ-036 Rising-edge detection SHALL be one sub-module btn_edge (registered input, pulse output), instantiated for left and right.

Verification
REQ-037 Bench SHALL use RELOAD_TICKS=16.
REQ-038 Reset, game_enable=1, cursor (210,310), duck (200,300) active, click -> shot_fired 1 cycle, bullets 2, target_killed 1, bin_number 1.
REQ-039 Cursor (264,310), duck (200,300), click -> bullets 2, target_killed 0, score 0 (right-edge exclusion).
REQ-040 Three misses then click -> bullets 0, fourth click gives no shot_fired; right edge -> bullets 3 exactly 16 cycles after RELOAD entry.
REQ-041 Left held high 100 cycles -> one shot only; hit with new_duck in the same cycle -> target_killed stays 1.
REQ-042 Score preset via 99 hits -> stays 99; game_enable 0 -> score holds 99; game_enable 1 -> score 0, bullets 3.
